issue_scoreboard_ctrl: RTL and testbench
========================================

Name: issue_scoreboard_ctrl

Overview:
- Issue controller between the decode stage and execute.
- Tracks in-flight destination registers in a per-register pending-write scoreboard and gates decode advance on RAW/WAW hazards.
- Sequences a post-redirect flush window.
- Produces the decode stage's issue-ready and flush controls.

Parameters:
NUM_REGS, 32, architectural integer registers; x0 is never tracked.
CNT_W, 2, pending-write counter width per register (max 2^CNT_W-1 writes in flight).
FLUSH_CYCLES, 2, cycles issue is blocked after a redirect (1..15).

Ports:
clk  input  1  clock
rst  input  1  bool_t; reset is synchronous and active-high
issue_valid  input  1  decode holds a valid decoded instruction
issue_has_rs1  input  1  instruction reads rs1
issue_rs1_num  input  5  rs1 index
issue_has_rs2  input  1  instruction reads rs2
issue_rs2_num  input  5  rs2 index
issue_has_rd  input  1  instruction writes rd
issue_rd_num  input  5  rd index
wb_valid  input  1  writeback retires a write this cycle
wb_rd_num  input  5  retiring rd
kill_valid  input  1  a squashed in-flight writer is dropped this cycle
kill_rd_num  input  5  squashed writer's rd
redirect  input  1  mispredict/redirect from execute
issue_rdy  output  1  decode may advance (combinational)
id_flush  output  1  invalidate the decode stage contents (registered)
sb_err  output  1  sticky: decrement of a zero counter observed

Behaviour:
- Scoreboard: pend[r], CNT_W bits, r in 1..NUM_REGS-1. pend[0] is constant 0. busy[r] = pend[r] != 0.
- issue_fire = issue_valid && issue_rdy.
- Per-cycle counter update for register r:
  - +1 if issue_fire && issue_has_rd && rd==r && r!=0.
  - -1 for each of wb_valid && wb_rd_num==r.
  - -1 for each of kill_valid && kill_rd_num==r.
  - Net update is applied in one cycle. Inc plus one dec on the same r leaves it unchanged. wb plus kill on the same r with no inc subtracts 2.
  - Result clamps at 0. Any clamp sets sb_err; sb_err clears only on rst.
- Hazard (all terms combinational):
  - raw = (has_rs1 && busy[rs1]) || (has_rs2 && busy[rs2]).
  - full = has_rd && rd!=0 && pend[rd] == max.
  - WAW is permitted; the counter handles it.
- FSM states: RUN, HOLD, FLUSH.
  - RUN: issue_rdy = !raw && !full. If issue_valid and (raw or full), go to HOLD.
  - HOLD: issue_rdy = !raw && !full. Return to RUN on the cycle the hazard clears (issue fires that cycle).
  - FLUSH: issue_rdy = 0. A down-counter is loaded with FLUSH_CYCLES-1 on entry; go to RUN when the counter is 0.
  - redirect in any state: next state FLUSH, counter reloaded, id_flush=1 next cycle. redirect overrides a same-cycle issue_fire: issue_rdy is forced 0 that cycle, so no scoreboard increment occurs.
  - id_flush is 1 in the first FLUSH cycle only.
- Latency: a wb in cycle N clears busy visible in cycle N+1. A stalled RAW consumer fires in N+1.
- Counters keep updating from wb/kill in every state, including FLUSH.
- Reset, while rst is high:
  - All pend=0, state=FLUSH, counter=FLUSH_CYCLES-1.
  - issue_rdy=0, id_flush=1, sb_err=0.
- Reset mid-operation discards all pending counts with no error reported. After rst deasserts, FLUSH runs for FLUSH_CYCLES, then RUN.
- issue_valid=0: no increment, and RUN/HOLD transitions are ignored (HOLD returns to RUN once the hazard clears).

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: a register is not busy for hazard purposes when wb_valid && wb_rd_num==r && pend[r]==1 in the same cycle. The RAW consumer fires in cycle N, and execute takes the value via the writeback bypass.
- Undefined: the behaviour above applies (fires in N+1). Scoreboard counter arithmetic is identical in both builds.

Decomposition:
- Shared package core gains:
  - sb_state_t enum (RUN, HOLD, FLUSH).
  - sb_cnt_t typedef.
  - sb_issue_t struct (has_rs1/rs1_num/has_rs2/rs2_num/has_rd/rd_num), packed from de_inst.
  - sb_wb_t struct (valid, rd_num).
  - Constant SB_CNT_MAX.
- One sub-module: sb_counter, a single saturating/clamping pending counter with inc, dec_a, dec_b and an underflow flag, instanced NUM_REGS-1 times.

Test Plan:
- Reset, then idle: issue_rdy=0 and id_flush=1 during rst; issue_rdy=0 for 2 cycles after deassert; issue_rdy=1 in the 3rd cycle with issue_valid=1, no regs read.
- RAW: issue rd=5 in cycle 0; cycle 1 issue rs1=5 -> issue_rdy=0 (HOLD). wb rd=5 in cycle 3 -> issue fires cycle 4 (cycle 3 with SB_WB_BYPASS_EN). pend[5] ends 0.
- Saturation, CNT_W=2: three issues with rd=7, then a fourth with rd=7 -> issue_rdy=0. One wb rd=7 -> fourth fires next cycle; pend[7]=3.
- Simultaneous events: pend[9]=2, then issue rd=9 + wb rd=9 + kill rd=9 in one cycle -> pend[9]=1. wb rd=12 with pend[12]=0 -> pend stays 0, sb_err=1 and stays 1.
- Redirect in the same cycle as a valid, hazard-free issue with rd=3: no increment (pend[3]=0); id_flush=1 next cycle; issue_rdy=0 for 2 cycles, then 1.
- x0: issue rd=0 and rs1=0 repeatedly -> never stalls, pend[0]=0; wb rd=0 does not set sb_err.

Source files
------------

// File: rtl/issue_scoreboard_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | issue_scoreboard_ctrl_pkg : shared types for the issue scoreboard |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package issue_scoreboard_ctrl_pkg;

  localparam int SB_REG_W = 5;
  localparam int SB_CNT_W = 2;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
  localparam sb_cnt_t SB_CNT_MAX = '1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } sb_state_t;

  typedef struct packed {
    logic                has_rs1;
    logic [SB_REG_W-1:0] rs1_num;
    logic                has_rs2;
    logic [SB_REG_W-1:0] rs2_num;
    logic                has_rd;
    logic [SB_REG_W-1:0] rd_num;
  } sb_issue_t;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rd_num;
  } sb_wb_t;

  // Register is a hazard source only if it is actually read and busy.
  function automatic logic sb_reads_busy(input logic has, input logic busy);
    return has && busy;
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_scoreboard_ctrl_sb_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sb_counter : one pending-write counter, clamps at 0 and at max    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec_a,
  input  logic         dec_b,
  output logic [W-1:0] cnt,
  output logic         underflow
);

  localparam logic signed [W+1:0] MAXV = {2'b00, {W{1'b1}}};

  logic signed [W+1:0] sum;
  logic [W-1:0]        cnt_nxt;

  // Net of one increment and up to two decrements, evaluated in a signed
  // width wide enough that -2 is representable before clamping.
  always_comb begin
    sum = $signed({2'b00, cnt})
        + $signed({{(W+1){1'b0}}, inc})
        - $signed({{(W+1){1'b0}}, dec_a})
        - $signed({{(W+1){1'b0}}, dec_b});
    underflow = 1'b0;
    cnt_nxt   = sum[W-1:0];
    if (sum < 0) begin
      underflow = 1'b1;
      cnt_nxt   = '0;
    end else if (sum > MAXV) begin
      cnt_nxt   = {W{1'b1}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/issue_scoreboard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | issue_scoreboard_ctrl : RAW/full issue gating + redirect flush    |
// | Optional macro SB_WB_BYPASS_EN : same-cycle writeback bypass      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module issue_scoreboard_ctrl
  import issue_scoreboard_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int CNT_W        = SB_CNT_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic       issue_has_rs1,
  input  logic [4:0] issue_rs1_num,
  input  logic       issue_has_rs2,
  input  logic [4:0] issue_rs2_num,
  input  logic       issue_has_rd,
  input  logic [4:0] issue_rd_num,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd_num,
  input  logic       kill_valid,
  input  logic [4:0] kill_rd_num,
  input  logic       redirect,
  output logic       issue_rdy,
  output logic       id_flush,
  output logic       sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  sb_issue_t iss;
  sb_wb_t    wb;
  sb_wb_t    kill;

  assign iss  = {issue_has_rs1, issue_rs1_num, issue_has_rs2, issue_rs2_num,
                 issue_has_rd, issue_rd_num};
  assign wb   = {wb_valid, wb_rd_num};
  assign kill = {kill_valid, kill_rd_num};

  logic [31:0][CNT_W-1:0] pend;
  logic [31:0]            busy;
  logic [31:0]            haz_busy;
  logic [31:0]            uflow;
  logic                   issue_fire;

  // The 5-bit index space is fully populated; x0 and indices beyond
  // NUM_REGS-1 read as permanently idle.
  generate
    for (genvar r = 0; r < 32; r++) begin : g_reg
      if (r == 0 || r >= NUM_REGS) begin : g_idle
        assign pend[r]  = '0;
        assign uflow[r] = 1'b0;
      end else begin : g_cnt
        sb_counter #(.W(CNT_W)) u_cnt (
          .clk       (clk),
          .rst       (rst),
          .inc       (issue_fire && iss.has_rd && iss.rd_num == 5'(r)),
          .dec_a     (wb.valid && wb.rd_num == 5'(r)),
          .dec_b     (kill.valid && kill.rd_num == 5'(r)),
          .cnt       (pend[r]),
          .underflow (uflow[r])
        );
      end

      assign busy[r] = (pend[r] != '0);

`ifdef SB_WB_BYPASS_EN
      assign haz_busy[r] = busy[r] &&
                           !(wb.valid && wb.rd_num == 5'(r) && pend[r] == CNT_ONE);
`else
      assign haz_busy[r] = busy[r];
`endif
    end
  endgenerate

  logic raw;
  logic full;
  logic hazard;

  assign raw    = sb_reads_busy(iss.has_rs1, haz_busy[iss.rs1_num]) ||
                  sb_reads_busy(iss.has_rs2, haz_busy[iss.rs2_num]);
  assign full   = iss.has_rd && (iss.rd_num != 5'd0) && (pend[iss.rd_num] == CNT_MAX);
  assign hazard = raw || full;

  sb_state_t  state;
  sb_state_t  state_nxt;
  logic [3:0] flush_cnt;
  logic [3:0] flush_cnt_nxt;

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    issue_rdy     = 1'b0;
    case (state)
      RUN: begin
        issue_rdy = !hazard;
        if (issue_valid && hazard) state_nxt = HOLD;
      end
      HOLD: begin
        issue_rdy = !hazard;
        if (!hazard) state_nxt = RUN;
      end
      FLUSH: begin
        if (flush_cnt == 4'd0) state_nxt = RUN;
        else                   flush_cnt_nxt = flush_cnt - 4'd1;
      end
      default: begin
        state_nxt     = FLUSH;
        flush_cnt_nxt = FLUSH_LOAD;
      end
    endcase
    // Redirect wins over a same-cycle issue so nothing is recorded for it.
    if (redirect) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = FLUSH_LOAD;
      issue_rdy     = 1'b0;
    end
    if (rst) issue_rdy = 1'b0;
  end

  assign issue_fire = issue_valid && issue_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      flush_cnt <= FLUSH_LOAD;
      id_flush  <= 1'b1;
      sb_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      id_flush  <= redirect;
      sb_err    <= sb_err | (|uflow);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_issue_scoreboard_ctrl : vector-table bench for the issue ctrl  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_issue_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic       issue_has_rs1 = 1'b0;
  logic [4:0] issue_rs1_num = '0;
  logic       issue_has_rs2 = 1'b0;
  logic [4:0] issue_rs2_num = '0;
  logic       issue_has_rd = 1'b0;
  logic [4:0] issue_rd_num = '0;
  logic       wb_valid = 1'b0;
  logic [4:0] wb_rd_num = '0;
  logic       kill_valid = 1'b0;
  logic [4:0] kill_rd_num = '0;
  logic       redirect = 1'b0;
  logic       issue_rdy;
  logic       id_flush;
  logic       sb_err;

  always #5 clk = ~clk;

  issue_scoreboard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_has_rs1 (issue_has_rs1),
    .issue_rs1_num (issue_rs1_num),
    .issue_has_rs2 (issue_has_rs2),
    .issue_rs2_num (issue_rs2_num),
    .issue_has_rd  (issue_has_rd),
    .issue_rd_num  (issue_rd_num),
    .wb_valid      (wb_valid),
    .wb_rd_num     (wb_rd_num),
    .kill_valid    (kill_valid),
    .kill_rd_num   (kill_rd_num),
    .redirect      (redirect),
    .issue_rdy     (issue_rdy),
    .id_flush      (id_flush),
    .sb_err        (sb_err)
  );

`ifdef SB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  // Register fields are {has, num}; 6'd0 means "not used".
  typedef struct {
    string      nm;
    logic       rs;
    logic       iv;
    logic [5:0] s1;
    logic [5:0] s2;
    logic [5:0] d;
    logic [5:0] w;
    logic [5:0] k;
    logic       rdr;
    logic       erdy;
    logic       efl;
    logic       eerr;
    int         preg;
    int         epend;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] NO = 6'd0;

  function automatic logic [5:0] R(input int n);
    return {1'b1, 5'(n)};
  endfunction

  task automatic add(input string nm, input logic rs, input logic iv,
                     input logic [5:0] s1, input logic [5:0] s2, input logic [5:0] d,
                     input logic [5:0] w, input logic [5:0] k, input logic rdr,
                     input logic erdy, input logic efl, input logic eerr,
                     input int preg, input int epend);
    vec_t v;
    v.nm = nm; v.rs = rs; v.iv = iv; v.s1 = s1; v.s2 = s2; v.d = d;
    v.w = w; v.k = k; v.rdr = rdr; v.erdy = erdy; v.efl = efl; v.eerr = eerr;
    v.preg = preg; v.epend = epend;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One cycle: drive just after the edge, sample on the falling edge.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst           = v.rs;
    issue_valid   = v.iv;
    issue_has_rs1 = v.s1[5]; issue_rs1_num = v.s1[4:0];
    issue_has_rs2 = v.s2[5]; issue_rs2_num = v.s2[4:0];
    issue_has_rd  = v.d[5];  issue_rd_num  = v.d[4:0];
    wb_valid      = v.w[5];  wb_rd_num     = v.w[4:0];
    kill_valid    = v.k[5];  kill_rd_num   = v.k[4:0];
    redirect      = v.rdr;
    @(negedge clk);
    chk({v.nm, ".rdy"},   int'(issue_rdy), int'(v.erdy));
    chk({v.nm, ".flush"}, int'(id_flush),  int'(v.efl));
    chk({v.nm, ".err"},   int'(sb_err),    int'(v.eerr));
    if (v.preg >= 0)
      chk($sformatf("%s.pend%0d", v.nm, v.preg), int'(dut.pend[v.preg]), v.epend);
  endtask

  task automatic run_hand(input string nm, input logic rs, input logic iv,
                          input logic [5:0] d, input logic [5:0] w, input logic [5:0] k,
                          input logic rdr, input logic erdy, input logic efl,
                          input logic eerr, input int preg, input int epend);
    vec_t v;
    v.nm = nm; v.rs = rs; v.iv = iv; v.s1 = NO; v.s2 = NO; v.d = d;
    v.w = w; v.k = k; v.rdr = rdr; v.erdy = erdy; v.efl = efl; v.eerr = eerr;
    v.preg = preg; v.epend = epend;
    step(v);
  endtask

  initial begin
    //   name       rs iv s1    s2  d      w      k      rdr rdy fl er preg pend
    add("rst",      1, 0, NO,   NO, NO,    NO,    NO,    0,  0,  1, 0, 5,   0);
    add("post1",    0, 1, NO,   NO, NO,    NO,    NO,    0,  0,  1, 0, -1,  0);
    add("post2",    0, 1, NO,   NO, NO,    NO,    NO,    0,  0,  0, 0, -1,  0);
    add("post3",    0, 1, NO,   NO, NO,    NO,    NO,    0,  1,  0, 0, -1,  0);
    add("raw_prod", 0, 1, NO,   NO, R(5),  NO,    NO,    0,  1,  0, 0, 5,   0);
    add("raw_hold", 0, 1, R(5), NO, NO,    NO,    NO,    0,  0,  0, 0, 5,   1);
    add("raw_hld2", 0, 1, R(5), NO, NO,    NO,    NO,    0,  0,  0, 0, 5,   1);
    add("raw_wb",   0, 1, R(5), NO, NO,    R(5),  NO,    0,  BYP,0, 0, 5,   1);
    add("raw_fire", 0, 1, R(5), NO, NO,    NO,    NO,    0,  1,  0, 0, 5,   0);
    add("sat1",     0, 1, NO,   NO, R(7),  NO,    NO,    0,  1,  0, 0, 7,   0);
    add("sat2",     0, 1, NO,   NO, R(7),  NO,    NO,    0,  1,  0, 0, 7,   1);
    add("sat3",     0, 1, NO,   NO, R(7),  NO,    NO,    0,  1,  0, 0, 7,   2);
    add("sat_full", 0, 1, NO,   NO, R(7),  NO,    NO,    0,  0,  0, 0, 7,   3);
    add("sat_wb",   0, 1, NO,   NO, R(7),  R(7),  NO,    0,  0,  0, 0, 7,   3);
    add("sat_fire", 0, 1, NO,   NO, R(7),  NO,    NO,    0,  1,  0, 0, 7,   2);
    add("sat_cnt",  0, 0, NO,   NO, NO,    NO,    NO,    0,  1,  0, 0, 7,   3);
    add("drain_wk", 0, 0, NO,   NO, NO,    R(7),  R(7),  0,  1,  0, 0, 7,   3);
    add("drain_w",  0, 0, NO,   NO, NO,    R(7),  NO,    0,  1,  0, 0, 7,   1);
    add("drained",  0, 0, R(7), NO, NO,    NO,    NO,    0,  1,  0, 0, 7,   0);
    add("x0_a",     0, 1, R(0), R(0),R(0), NO,    NO,    0,  1,  0, 0, 0,   0);
    add("x0_b",     0, 1, R(0), NO, R(0),  NO,    NO,    0,  1,  0, 0, 0,   0);
    add("x0_wb",    0, 1, R(0), NO, R(0),  R(0),  NO,    0,  1,  0, 0, 0,   0);
    add("x0_noerr", 0, 0, NO,   NO, NO,    NO,    NO,    0,  1,  0, 0, 0,   0);
    add("sim1",     0, 1, NO,   NO, R(9),  NO,    NO,    0,  1,  0, 0, 9,   0);
    add("sim2",     0, 1, NO,   NO, R(9),  NO,    NO,    0,  1,  0, 0, 9,   1);
    add("sim_iwk",  0, 1, NO,   NO, R(9),  R(9),  R(9),  0,  1,  0, 0, 9,   2);
    add("sim_res",  0, 0, NO,   NO, NO,    R(12), NO,    0,  1,  0, 0, 9,   1);
    add("err_set",  0, 0, NO,   NO, NO,    R(9),  NO,    0,  1,  0, 1, 12,  0);
    add("err_stk",  0, 0, NO,   NO, NO,    NO,    NO,    0,  1,  0, 1, 9,   0);
    add("redir",    0, 1, NO,   NO, R(3),  NO,    NO,    1,  0,  0, 1, 3,   0);
    add("flush1",   0, 1, NO,   NO, NO,    NO,    NO,    0,  0,  1, 1, 3,   0);
    add("flush2",   0, 1, NO,   NO, NO,    NO,    NO,    0,  0,  0, 1, 3,   0);
    add("flush_ok", 0, 1, NO,   NO, NO,    NO,    NO,    0,  1,  0, 1, 3,   0);

    repeat (2) @(posedge clk);
    foreach (tbl[i]) step(tbl[i]);

    // Reset in mid-operation discards pending counts and the sticky error.
    //        name         rs iv d      w      k      rdr rdy fl er preg pend
    run_hand("mr_issue",   0, 1, R(4),  NO,    NO,    0,  1,  0, 1, 4,   0);
    run_hand("mr_rst",     1, 1, R(4),  NO,    NO,    0,  0,  0, 1, 4,   1);
    run_hand("mr_post1",   0, 0, NO,    NO,    NO,    0,  0,  1, 0, 4,   0);
    run_hand("mr_post2",   0, 0, NO,    NO,    NO,    0,  0,  0, 0, 4,   0);
    run_hand("mr_post3",   0, 0, NO,    NO,    NO,    0,  1,  0, 0, 4,   0);

    // WAW is allowed; wb/kill keep draining the counter through a flush.
    run_hand("waw1",       0, 1, R(6),  NO,    NO,    0,  1,  0, 0, 6,   0);
    run_hand("waw2",       0, 1, R(6),  NO,    NO,    0,  1,  0, 0, 6,   1);
    run_hand("rd_kill",    0, 0, NO,    NO,    R(6),  1,  0,  0, 0, 6,   2);
    run_hand("fl_wb",      0, 0, NO,    R(6),  NO,    0,  0,  1, 0, 6,   1);
    run_hand("fl_end",     0, 0, NO,    NO,    NO,    0,  0,  0, 0, 6,   0);
    run_hand("fl_run",     0, 0, NO,    NO,    NO,    0,  1,  0, 0, 6,   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
